// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared definitions for the instruction-fetch front end.
//   NOP_INSN  : word presented on a miss or a misaligned fetch.
//   state_e   : request FSM states (IDLE, REQ, WAIT).
//   entry_t   : one prefetch-buffer entry {valid, word address, data}.
//   next_word : sequential successor of a word address (wraps at 2^30 words).
package ifetch_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
  } entry_t;

  // Word address of pc+4; the 30-bit add wraps 0xFFFF_FFFC to 0x0.
  function automatic logic [29:0] next_word(input logic [29:0] word);
    return word + 30'd1;
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf -- two-entry fetch buffer with parallel lookup.
//   clk, rst_n     : clock, asynchronous active-low reset (clears all entries)
//   pc_word        : pc[31:2] of the current fetch
//   wr_en          : write a returned word this cycle
//   wr_addr        : word address of the returned word
//   wr_data        : returned word
//   hit            : pc_word is held in a valid entry
//   hit_data       : data of the hitting entry (NOP_INSN when no hit)
//   next_present   : pc_word+1 is held in a valid entry
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] pc_word,
  input  logic        wr_en,
  input  logic [29:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        hit,
  output logic [31:0] hit_data,
  output logic        next_present
);

  entry_t      entry_q [2];
  entry_t      entry_d [2];
  logic [1:0]  hit_vec_s;
  logic [1:0]  next_vec_s;
  logic [29:0] next_word_s;
  logic        victim_s;

  // Lookup of pc and pc+4 against both entries.
  always_comb begin
    hit_vec_s   = 2'b00;
    next_vec_s  = 2'b00;
    next_word_s = next_word(pc_word);
    for (int i = 0; i < 2; i++) begin
      hit_vec_s[i]  = entry_q[i].valid && (entry_q[i].addr == pc_word);
      next_vec_s[i] = entry_q[i].valid && (entry_q[i].addr == next_word_s);
    end
  end

  // Hit data mux; no-hit presents the NOP word.
  always_comb begin
    hit          = |hit_vec_s;
    next_present = |next_vec_s;
    if (hit_vec_s[0]) begin
      hit_data = entry_q[0].data;
    end else if (hit_vec_s[1]) begin
      hit_data = entry_q[1].data;
    end else begin
      hit_data = NOP_INSN;
    end
  end

  // Victim is the entry not serving the current pc, so a write never
  // disturbs the word being read this cycle; with no hit, E0 is used.
  always_comb begin
    victim_s   = hit_vec_s[0] ? 1'b1 : 1'b0;
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    if (wr_en) begin
      entry_d[victim_s] = '{valid: 1'b1, addr: wr_addr, data: wr_data};
    end else begin
      entry_d[victim_s] = entry_q[victim_s];
    end
  end

  // Entry storage; only reset invalidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

endmodule

// File: rtl/ifetch_port.sv
// ifetch_port -- instruction-fetch front end with a two-entry prefetch buffer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   pc              : fetch address from decode, held while fetch_stall=1
//   instruction     : word for pc (NOP_INSN on miss or fault), combinational
//   fetch_stall     : aligned pc not yet buffered, combinational
//   fetch_fault     : pc[1:0] != 0, combinational
//   mem_req_valid   : registered request valid (one outstanding request)
//   mem_req_addr    : registered word-aligned request address
//   mem_req_ready   : memory accepts on valid & ready
//   mem_resp_valid  : response strobe, honoured only while waiting
//   mem_resp_data   : response word
module ifetch_port
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        fetch_stall,
  output logic        fetch_fault,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  state_e      state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic        fault_s;
  logic        hit_s;
  logic        next_present_s;
  logic [31:0] hit_data_s;
  logic        buf_wr_en_s;

  ifetch_buf u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_word      (pc[31:2]),
    .wr_en        (buf_wr_en_s),
    .wr_addr      (req_addr_q[31:2]),
    .wr_data      (mem_resp_data),
    .hit          (hit_s),
    .hit_data     (hit_data_s),
    .next_present (next_present_s)
  );

  // Decode-facing outputs; a misaligned pc never stalls and yields NOP.
  always_comb begin
    fault_s     = (pc[1:0] != 2'b00);
    fetch_fault = fault_s;
    fetch_stall = !fault_s && !hit_s;
    if (!fault_s && hit_s) begin
      instruction = hit_data_s;
    end else begin
      instruction = NOP_INSN;
    end
  end

  // Request FSM: demand miss has priority over sequential prefetch; an
  // accepted request always runs to its response even if pc redirects.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    buf_wr_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fault_s && !hit_s) begin
          req_addr_d  = {pc[31:2], 2'b00};
          req_valid_d = 1'b1;
          state_d     = REQ;
        end else if (!fault_s && hit_s && !next_present_s) begin
          req_addr_d  = {next_word(pc[31:2]), 2'b00};
          req_valid_d = 1'b1;
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          buf_wr_en_s = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // FSM state and bus registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;

endmodule

// File: tb/tb_ifetch_port.sv
// tb_ifetch_port -- scoreboard bench for ifetch_port. Stimulus pushes the
// expected word for each pc into a queue; a monitor pops and compares
// whenever the DUT stops stalling. A memory responder model serves requests
// from a hash-defined memory image and checks bus-protocol rules.
module tb_ifetch_port;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        fetch_stall;
  logic        fetch_fault;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  ifetch_port dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instruction    (instruction),
    .fetch_stall    (fetch_stall),
    .fetch_fault    (fetch_fault),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // responder controls
  logic        rand_ready = 1'b0;
  logic        tb_ready   = 1'b1;
  logic        rnd_ready  = 1'b1;
  logic        rand_lat   = 1'b0;
  int          lat        = 1;
  int          spur_rate  = 0;

  assign mem_req_ready = rand_ready ? rnd_ready : tb_ready;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  task automatic set_pc(input logic [31:0] a);
    exp_t e;
    pc      = a;
    e.pc    = a;
    e.fault = (a[1:0] != 2'b00);
    e.insn  = e.fault ? NOP : mem_fn({a[31:2], 2'b00});
    exp_q.push_back(e);
  endtask

  task automatic wait_served(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("serve", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_q.delete();
  endtask

  // Monitor: compare whenever the DUT presents a word; while stalled it must show NOP.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!fetch_stall) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("insn", instruction, e.insn);
            chk("fault", {31'b0, fetch_fault}, {31'b0, e.fault});
          end
        end else begin
          chk("stall_nop", instruction, NOP);
          chk("stall_nofault", {31'b0, fetch_fault}, 32'h0);
        end
      end
    end
  end

  // Memory responder with protocol checks.
  initial begin
    int          cnt;
    logic        acc, hold_pend;
    logic [31:0] acc_addr, hold_addr, resp_addr;
    cnt = 0; hold_pend = 1'b0; resp_addr = 32'h0; hold_addr = 32'h0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc      = rst_n && mem_req_valid && mem_req_ready;
      acc_addr = mem_req_addr;
      if (rst_n && hold_pend) begin
        chk("hold_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("hold_addr", mem_req_addr, hold_addr);
      end
      if (rst_n && mem_req_valid) chk("addr_align", {30'b0, mem_req_addr[1:0]}, 32'h0);
      hold_pend = rst_n && mem_req_valid && !mem_req_ready;
      hold_addr = mem_req_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cnt = 0; hold_pend = 1'b0; mem_resp_valid = 1'b0;
      end else begin
        if (acc) begin
          acc_q.push_back(acc_addr);
          resp_addr = acc_addr;
          cnt = rand_lat ? int'($urandom_range(1, 3)) : lat;
        end
        if (cnt == 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_fn(resp_addr);
          cnt = 0;
        end else if (cnt > 1) begin
          mem_resp_valid = 1'b0;
          cnt--;
        end else begin
          mem_resp_valid = (int'($urandom_range(0, 3)) < spur_rate);
          mem_resp_data  = $urandom;
        end
      end
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    logic [31:0] seq_exp [5];
    logic [31:0] base;
    int          r;
    seq_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    rst_n = 1'b0;
    pc    = 32'h0;

    // Reset state and first demand fetch with zero-wait memory.
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_addr", mem_req_addr, 32'h0);
    chk("rst_stall", {31'b0, fetch_stall}, 32'h1);
    chk("rst_insn", instruction, NOP);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_q.delete();
    set_pc(32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 3) chk("first_stall", {31'b0, fetch_stall}, 32'h1);
      if (c == 1) begin
        chk("first_req_v", {31'b0, mem_req_valid}, 32'h1);
        chk("first_req_a", mem_req_addr, 32'h0);
      end
      if (c == 3) begin
        chk("first_hit", {31'b0, fetch_stall}, 32'h0);
        chk("first_insn", instruction, 32'h0000_0093);
      end
      if (c == 4) begin
        chk("pf_req_v", {31'b0, mem_req_valid}, 32'h1);
        chk("pf_req_a", mem_req_addr, 32'h4);
      end
    end

    // Sequential code: each next word is already buffered.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i < 4; i++) begin
      set_pc(32'(i * 4));
      @(negedge clk);
      chk("seq_hit", {31'b0, fetch_stall}, 32'h0);
      repeat (4) @(posedge clk);
      #1;
    end
    chk("seq_nreq", acc_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < acc_q.size()) chk("seq_addr", acc_q[i], seq_exp[i]);
    end

    // Redirect while a prefetch is outstanding.
    do_reset();
    lat = 4;
    set_pc(32'h100);
    wait_served(40);
    #1;
    repeat (2) @(posedge clk);
    #1;
    set_pc(32'h200);
    wait_served(60);
    chk("redir_nreq", {31'b0, acc_q.size() >= 3}, 32'h1);
    if (acc_q.size() >= 3) begin
      chk("redir_pf", acc_q[1], 32'h104);
      chk("redir_dem", acc_q[2], 32'h200);
    end

    // Misaligned pc: fault, no stall, no request.
    do_reset();
    lat = 1;
    set_pc(32'h0000_0102);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mis_valid", {31'b0, mem_req_valid}, 32'h0);
      chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
      chk("mis_stall", {31'b0, fetch_stall}, 32'h0);
      chk("mis_insn", instruction, NOP);
    end

    // Back-pressure, plus spurious responses outside WAIT.
    @(posedge clk);
    #1;
    tb_ready  = 1'b0;
    spur_rate = 4;
    set_pc(32'h300);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, mem_req_valid}, 32'h1);
      chk("bp_addr", mem_req_addr, 32'h300);
    end
    @(posedge clk);
    #1;
    tb_ready = 1'b1;
    wait_served(40);
    repeat (8) @(posedge clk);
    #1;
    spur_rate = 0;
    set_pc(32'h304);
    wait_served(20);

    // Wrap-around prefetch, then reset during WAIT.
    do_reset();
    set_pc(32'hFFFF_FFFC);
    wait_served(20);
    #1;
    lat = 6;
    @(negedge clk);
    chk("wrap_v", {31'b0, mem_req_valid}, 32'h1);
    chk("wrap_a", mem_req_addr, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rstw_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rstw_addr", mem_req_addr, 32'h0);
    chk("rstw_stall", {31'b0, fetch_stall}, 32'h1);
    chk("rstw_insn", instruction, NOP);
    lat = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic.
    do_reset();
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    spur_rate  = 1;
    base = 32'h1000;
    set_pc(base);
    for (int it = 0; it < 300; it++) begin
      wait_served(80);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        base = base + 32'd4;
        set_pc(base);
      end else if (r < 80) begin
        base = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
        set_pc(base);
      end else if (r < 88) begin
        base = base - 32'd4;
        set_pc(base);
      end else if (r < 93) begin
        set_pc(base);
      end else begin
        set_pc(base | 32'($urandom_range(1, 3)));
      end
    end
    wait_served(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_port.md
# ifetch_port

Instruction-fetch front end that sits directly upstream of the decode/control stage. It takes that stage's `pc`, returns the 32-bit `instruction` for it, and holds the stage with `fetch_stall` until the word is present. It connects to a valid/ready instruction-memory bus that allows one outstanding request. A two-entry buffer with sequential next-word prefetch hides memory latency on straight-line code.

## Interface
- `NOP_INSN`, 32'h0000_0013, word driven on `instruction` whenever no valid word is available (miss or fault).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `pc` in 32: current PC from decode stage; held stable by that stage while `fetch_stall`=1.
- `instruction` out 32: fetched word for `pc`, combinational.
- `fetch_stall` out 1: combinational, 1 when `pc` is aligned and not present in the buffer.
- `fetch_fault` out 1: combinational, 1 when `pc[1:0]`≠0.
- `mem_req_valid` out 1: registered request valid.
- `mem_req_addr` out 32: registered word address, bits [1:0] always 0.
- `mem_req_ready` in 1: memory accepts the request on an edge where valid & ready.
- `mem_resp_valid` in 1: response strobe, earliest one cycle after acceptance.
- `mem_resp_data` in 32: response word, sampled when `mem_resp_valid`=1.

## Operation
- Buffer: entries E0 and E1, each holding {valid, addr[31:2], data[31:0]}.
- Hit: a valid entry with addr = `pc[31:2]`. On a hit, `instruction` = that entry's data and `fetch_stall`=0.
- Misaligned `pc` (`fetch_fault`=1): `instruction`=`NOP_INSN`, `fetch_stall`=0, no request issued. The core top routes the fault to the CSR trap logic.
- Aligned miss: `instruction`=`NOP_INSN`, `fetch_stall`=1.
- FSM states:
  - IDLE: request target selection, in priority order:
    - Demand: `pc` aligned and missing → target `pc`.
    - Prefetch: `pc` hits and `pc+4` (mod 2^32, wraps at 0xFFFF_FFFC→0) is in no entry → target `pc+4`.
    - Otherwise stay in IDLE.
    - When a target is chosen: latch `mem_req_addr`, set `mem_req_valid`=1, go to REQ.
  - REQ: hold valid and address until `mem_req_ready`, then clear `mem_req_valid` and go to WAIT.
  - WAIT: on `mem_resp_valid`, write the victim entry {1, req_addr, data} and go to IDLE.
- Victim selection: the entry that does not hit current `pc`. If neither entry hits, the victim is E0. This gives ping-pong placement on sequential code.
- An accepted request is never aborted. If `pc` redirects (jump or trap) while a prefetch is in WAIT, the response is still written and the demand fetch for the new `pc` issues from the following IDLE cycle.
- `mem_resp_valid` outside WAIT is ignored.
- Entries are never invalidated except by reset; there is no self-modifying-code support.

## Timing
- Reset values:
  - All entries invalid.
  - State IDLE.
  - `mem_req_valid`=0, `mem_req_addr`=0.
  - Therefore `fetch_stall`=1 and `instruction`=`NOP_INSN` for an aligned `pc`.
- Demand miss with zero-wait memory (ready=1 in REQ, response one cycle after acceptance):
  - Miss seen in IDLE at cycle t.
  - `mem_req_valid` high in t+1.
  - Response in t+2.
  - Hit and `fetch_stall`=0 in t+3.
- Prefetch issues in the cycle after a hit is seen in IDLE. With zero-wait memory, back-to-back sequential hits are sustained once the first word has been fetched and its prefetch has landed.
- Simultaneous response write and hit read: the write only ever targets the non-hit entry, so a hit's output never changes mid-cycle.
- `rst_n` asserted mid-transaction: all state clears immediately. The memory bus shares `rst_n`, so no stale response arrives after release.

## Structure
- Shared package `ifetch_pkg`: `NOP_INSN`, state enum (IDLE, REQ, WAIT), and the entry struct type.
- Sub-module `ifetch_buf`: two entries, parallel hit compare for `pc` and `pc+4`, victim select, write port.
- Top level keeps the FSM and bus registers.

## Test plan
- Reset, `pc`=0, memory returns 0x0000_0093 with zero wait → `fetch_stall`=1 for cycles 0-2; cycle 3: `instruction`=0x0000_0093, `fetch_stall`=0; next request addr=0x4.
- Sequential `pc` 0x0,0x4,0x8,0xC with zero-wait memory → after the first fetch, each `pc+4` word is buffered; `mem_req_addr` sequence 0x0,0x4,0x8,0xC,0x10; E0/E1 alternate.
- Prefetch of 0x104 in WAIT while `pc` jumps to 0x200 → 0x104 written, then demand request 0x200; `fetch_stall` held until 0x200 data returns.
- `pc`=0x0000_0102 → `fetch_fault`=1, `fetch_stall`=0, `instruction`=0x0000_0013, `mem_req_valid` stays 0.
- `mem_req_ready` low for 5 cycles → `mem_req_valid` and `mem_req_addr` stable throughout; a spurious `mem_resp_valid` in IDLE does not write any entry.
- `pc`=0xFFFF_FFFC hit → prefetch addr 0x0000_0000; assert `rst_n` low during WAIT → all entries invalid and `mem_req_valid`=0 immediately.
